// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous RAM (read-first, 1-cycle read)
// between NUM_REQ requesters; routes registered read data back to the granted requester.
module ram_port_arbiter #(
  parameter int data_width    = 8,
  parameter int address_width = 7,
  parameter int NUM_REQ       = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ-1:0]               req_we,
  input  logic [NUM_REQ*address_width-1:0] req_add,
  input  logic [NUM_REQ*data_width-1:0]    req_data_w,
  output logic [NUM_REQ-1:0]               rsp_valid,
  output logic [data_width-1:0]            rsp_data,
  output logic                             mem_we,
  output logic [address_width-1:0]         mem_add,
  output logic [data_width-1:0]            mem_data_w,
  input  logic [data_width-1:0]            mem_data_r
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [IDX_W-1:0] LAST_GNT_RST = IDX_W'(NUM_REQ - 1);

  logic [IDX_W-1:0] last_gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_any;
  logic [IDX_W-1:0] sel;
  logic             tag_valid;
  logic [IDX_W-1:0] tag_idx;

  // Rotating priority scan starting just after the last winner.
  always_comb begin
    int               idx;
    logic [IDX_W-1:0] cand;
    gnt_idx = last_gnt;
    gnt_any = 1'b0;
    idx     = 0;
    cand    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx  = (int'(last_gnt) + 1 + k) % NUM_REQ;
      cand = IDX_W'(idx);
      if (!gnt_any && !rst && req_valid[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = gnt_any && (gnt_idx == IDX_W'(i));
    end
  end

  // When idle the port keeps pointing at the last winner's slice, so it holds its value.
  assign sel        = gnt_any ? gnt_idx : last_gnt;
  assign mem_add    = req_add[int'(sel)*address_width +: address_width];
  assign mem_data_w = req_data_w[int'(sel)*data_width +: data_width];
  assign mem_we     = gnt_any && req_we[gnt_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      last_gnt  <= LAST_GNT_RST;
      tag_valid <= 1'b0;
      tag_idx   <= '0;
    end else begin
      if (gnt_any) begin
        last_gnt <= gnt_idx;
      end
      tag_valid <= gnt_any && !req_we[gnt_idx];
      tag_idx   <= gnt_idx;
    end
  end

  // Gating with rst drops a response whose read was granted just before reset.
  always_comb begin
    rsp_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rsp_valid[i] = tag_valid && !rst && (tag_idx == IDX_W'(i));
    end
  end

  assign rsp_data = mem_data_r;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter: 2-requester instance with a read-first RAM model,
// plus a 4-requester instance for fairness.
module tb_ram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic [1:0]  req_valid = '0, req_ready, req_we = '0, rsp_valid;
  logic [13:0] req_add = '0;
  logic [15:0] req_data_w = '0;
  logic [7:0]  rsp_data, mem_data_w, mem_data_r;
  logic [6:0]  mem_add;
  logic        mem_we;

  logic [3:0]  req_valid4 = '0, req_ready4, req_we4 = '0, rsp_valid4;
  logic [27:0] req_add4 = '0;
  logic [31:0] req_data_w4 = '0;
  logic [7:0]  rsp_data4, mem_data_w4, mem_data_r4;
  logic [6:0]  mem_add4;
  logic        mem_we4;

  logic [7:0]  ram2 [0:127];
  logic [7:0]  ram4 [0:127];

  int n_tests = 0;
  int n_fail  = 0;
  int gcount [0:3];

  always #5 clk = ~clk;

  ram_port_arbiter #(.data_width(8), .address_width(7), .NUM_REQ(2)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_add(req_add), .req_data_w(req_data_w), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .mem_we(mem_we), .mem_add(mem_add), .mem_data_w(mem_data_w), .mem_data_r(mem_data_r)
  );

  ram_port_arbiter #(.data_width(8), .address_width(7), .NUM_REQ(4)) u_dut4 (
    .clk(clk), .rst(rst), .req_valid(req_valid4), .req_ready(req_ready4), .req_we(req_we4),
    .req_add(req_add4), .req_data_w(req_data_w4), .rsp_valid(rsp_valid4), .rsp_data(rsp_data4),
    .mem_we(mem_we4), .mem_add(mem_add4), .mem_data_w(mem_data_w4), .mem_data_r(mem_data_r4)
  );

  // Read-first single-port RAM models
  always @(posedge clk) begin
    if (mem_we) ram2[mem_add] <= mem_data_w;
    mem_data_r <= ram2[mem_add];
    if (mem_we4) ram4[mem_add4] <= mem_data_w4;
    mem_data_r4 <= ram4[mem_add4];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic we, input logic [6:0] a, input logic [7:0] d);
    req_valid[i]          = 1'b1;
    req_we[i]             = we;
    req_add[i*7 +: 7]     = a;
    req_data_w[i*8 +: 8]  = d;
  endtask

  task automatic drop(input int i);
    req_valid[i] = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4; i++) gcount[i] = 0;

    // Reset: requests present but nothing granted
    set_req(0, 1'b1, 7'h10, 8'h5A);
    set_req(1, 1'b1, 7'h20, 8'h33);
    req_valid4 = 4'hF;
    req_we4    = 4'hF;
    @(negedge clk);
    check("rst_ready", req_ready, 2'b00);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_rsp_valid", rsp_valid, 2'b00);
    check("rst_ready4", req_ready4, 4'h0);
    check("rst_mem_we4", mem_we4, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    drop(1);
    req_valid4 = 4'h0;
    req_we4    = 4'h0;

    // Write 0x5A @0x10, then read it back
    @(negedge clk);
    check("t1_c1_ready", req_ready, 2'b01);
    check("t1_c1_mem_we", mem_we, 1'b1);
    check("t1_c1_mem_add", mem_add, 7'h10);
    check("t1_c1_mem_data_w", mem_data_w, 8'h5A);
    tick();
    set_req(0, 1'b0, 7'h10, 8'h00);
    @(negedge clk);
    check("t1_c2_ready", req_ready, 2'b01);
    check("t1_c2_mem_we", mem_we, 1'b0);
    check("t1_c2_rsp_after_write", rsp_valid, 2'b00);
    tick();
    drop(0);
    @(negedge clk);
    check("t1_c3_rsp_valid", rsp_valid, 2'b01);
    check("t1_c3_rsp_data", rsp_data, 8'h5A);
    check("t1_c3_idle_ready", req_ready, 2'b00);
    check("t1_c3_idle_mem_we", mem_we, 1'b0);
    check("t1_c3_hold_mem_add", mem_add, 7'h10);
    tick();

    // Preload 0x11 @0x01 (req0), 0x22 @0x02 (req1)
    set_req(0, 1'b1, 7'h01, 8'h11);
    @(negedge clk);
    check("pre_w0_ready", req_ready, 2'b01);
    tick();
    drop(0);
    set_req(1, 1'b1, 7'h02, 8'h22);
    @(negedge clk);
    check("pre_w1_ready", req_ready, 2'b10);
    tick();
    drop(1);
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // Both reading continuously from reset: alternate grants, responses one behind
    set_req(0, 1'b0, 7'h01, 8'h00);
    set_req(1, 1'b0, 7'h02, 8'h00);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check($sformatf("t2_ready_%0d", k), req_ready, (k % 2) ? 2'b10 : 2'b01);
      if (k == 0) begin
        check("t2_rsp_valid_0", rsp_valid, 2'b00);
      end else begin
        check($sformatf("t2_rsp_valid_%0d", k), rsp_valid, (k % 2) ? 2'b01 : 2'b10);
        check($sformatf("t2_rsp_data_%0d", k), rsp_data, (k % 2) ? 8'h11 : 8'h22);
      end
      tick();
    end

    // req1 alone three cycles, then both: req0 first
    drop(0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("t3_solo1_ready_%0d", k), req_ready, 2'b10);
      tick();
    end
    set_req(0, 1'b0, 7'h01, 8'h00);
    @(negedge clk);
    check("t3_both_ready_a", req_ready, 2'b01);
    check("t3_both_rsp_valid_a", rsp_valid, 2'b10);
    check("t3_both_rsp_data_a", rsp_data, 8'h22);
    tick();
    @(negedge clk);
    check("t3_both_ready_b", req_ready, 2'b10);
    check("t3_both_rsp_valid_b", rsp_valid, 2'b01);
    check("t3_both_rsp_data_b", rsp_data, 8'h11);
    tick();
    drop(0);

    // Write 0xA5 @0x7F then immediate read of the same address
    set_req(1, 1'b1, 7'h7F, 8'hA5);
    @(negedge clk);
    check("t4_w_ready", req_ready, 2'b10);
    check("t4_w_mem_we", mem_we, 1'b1);
    check("t4_w_mem_add", mem_add, 7'h7F);
    check("t4_w_mem_data_w", mem_data_w, 8'hA5);
    tick();
    set_req(1, 1'b0, 7'h7F, 8'h00);
    @(negedge clk);
    check("t4_r_ready", req_ready, 2'b10);
    check("t4_no_rsp_after_write", rsp_valid, 2'b00);
    tick();
    drop(1);
    @(negedge clk);
    check("t4_rsp_valid", rsp_valid, 2'b10);
    check("t4_rsp_data", rsp_data, 8'hA5);
    check("t4_hold_mem_add", mem_add, 7'h7F);
    tick();

    // Read granted, then reset in the following cycle
    set_req(0, 1'b0, 7'h10, 8'h00);
    @(negedge clk);
    check("t5_read_ready", req_ready, 2'b01);
    tick();
    rst = 1'b1;
    set_req(1, 1'b0, 7'h7F, 8'h00);
    @(negedge clk);
    check("t5_rst_rsp_valid", rsp_valid, 2'b00);
    check("t5_rst_ready", req_ready, 2'b00);
    check("t5_rst_mem_we", mem_we, 1'b0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("t5_after_rst_ready", req_ready, 2'b01);
    check("t5_after_rst_rsp_valid", rsp_valid, 2'b00);
    tick();
    drop(0);
    drop(1);

    // Four requesters, all reading for 8 cycles
    req_valid4 = 4'hF;
    req_we4    = 4'h0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check($sformatf("t6_ready4_%0d", k), req_ready4, 4'b0001 << (k % 4));
      for (int i = 0; i < 4; i++) if (req_ready4[i]) gcount[i]++;
      if (k > 0) check($sformatf("t6_rsp_valid4_%0d", k), rsp_valid4, 4'b0001 << ((k - 1) % 4));
      tick();
    end
    req_valid4 = 4'h0;
    for (int i = 0; i < 4; i++) check($sformatf("t6_grant_count_%0d", i), gcount[i], 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
